laser_cmd_sched: RTL and testbench
==================================

# laser_cmd_sched

Command scheduler for the laser serial link. It shares the single laser UART TX/RX path between `REQ_NUM` requesters. Each requester issues one 32-bit command word. The block sends the word to the laser comm controller, then collects the reply bytes until the `8'hFF` end-of-frame byte arrives or a timeout expires. It returns the packed reply and a status to the requester that issued the command. The block sits between the register/command decoders and the laser comm controller's `laser_tx_*` / `laser_rx_*` ports.

## Interface
- `REQ_NUM`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 10_000_000: clk_i cycles allowed from command send to the `8'hFF` reply byte.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in REQ_NUM: per-requester command request, level.
- `req_data_i` in REQ_NUM*32: packed command words; requester i uses `[32*i+31:32*i]`.
- `ack_o` out REQ_NUM: one-cycle completion pulse to the granted requester.
- `rsp_data_o` out 32: reply bytes from the last transaction.
- `rsp_err_o` out 1: 1 = last transaction timed out.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `laser_tx_data_o` out 32: command word sent to the comm controller.
- `laser_tx_vld_o` out 1: one-cycle write strobe.
- `laser_rx_data_i` in 8: reply byte.
- `laser_rx_vld_i` in 1: reply byte valid.
- `laser_rx_last_i` in 1: reply byte is `8'hFF`.

## Operation
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - if `|req_i`, grant the requester chosen round-robin, latch its word, clear `rsp_data_o` shadow and timer, go to SEND.
  - otherwise stay in IDLE.
- Round-robin:
  - priority pointer is 0 after reset.
  - after a grant to i, requester (i+1) mod REQ_NUM has highest priority.
- SEND: `laser_tx_vld_o`=1 with the latched word for exactly one cycle, then go to WAIT_RSP.
- WAIT_RSP:
  - timer counts up each cycle.
  - on `laser_rx_vld_i`, shift the byte in: `rsp <= {rsp[23:0], byte}`. Only the last 4 bytes are kept, including `8'hFF` in bits [7:0].
  - on `laser_rx_last_i`, go to DONE with err=0.
  - when timer reaches TIMEOUT_CYC-1, take the timeout action (see Configuration).
  - `rx_last` and timeout in the same cycle: `rx_last` wins, err=0.
- DONE:
  - `ack_o[grant]`=1 for one cycle.
  - `rsp_data_o` and `rsp_err_o` update this cycle and hold until the next DONE.
  - next state is IDLE.
- Requester contract:
  - hold `req_i` and `req_data_i` stable until ack.
  - drop `req` no later than the cycle after ack. `req` still high in the following IDLE cycle is treated as a new command.
  - a `req` dropped mid-transaction does not abort it; ack still pulses.
- Reply bytes arriving in IDLE, SEND or DONE are discarded.
- Reset (any time, including mid-transaction):
  - state goes to IDLE.
  - all outputs, the pointer, the timer and the shadow registers go to 0.
- A byte already handed to the UART is not recalled.

## Timing
- Reset values: `ack_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `busy_o`=0, `laser_tx_data_o`=0, `laser_tx_vld_o`=0.
- All outputs are registered.
- `req` sampled at edge k in IDLE → `laser_tx_vld_o` high in cycle k+1, `busy_o` high from k+1.
- `laser_rx_last_i` at edge m → `ack_o` high in cycle m+1 → IDLE at m+2 (`busy_o` low).
- Earliest next `laser_tx_vld_o` is m+3.
- Timer is 32 bits and does not wrap. Timeout fires in the cycle where timer==TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after SEND.

## Configuration
- `LASER_CMD_RETRY_EN` defined: on the first timeout, clear timer and rsp shadow and return to SEND, resending the same word once. A second timeout goes to DONE with err=1.
- Macro undefined: the first timeout goes to DONE with err=1.

## Structure
- Package `laser_cmd_pkg` holds:
  - state enum (IDLE=0, SEND=1, WAIT_RSP=2, DONE=3);
  - `LASER_EOF` = `8'hFF`;
  - `LASER_CMD_W` = 32.
- Sub-module `laser_rr_arbiter`: combinational one-hot grant from `req_i` and pointer. The pointer register lives in the parent.

## Test plan
- Single request: req0 with `32'h1122_33FF`, reply 11,22,33,FF → tx word `32'h1122_33FF` in cycle k+1; `ack_o`=0001 one cycle after FF; `rsp_data_o`=`32'h1122_33FF`, err=0.
- Contention: req0..3 all high from reset → grant order 0,1,2,3. Then req0 and req2 high again → order 0,2.
- Timeout: TIMEOUT_CYC=100, no reply:
  - without macro: ack after 100 cycles, err=1, `rsp_data_o`=0.
  - with `LASER_CMD_RETRY_EN`: two tx strobes, ack after 200 cycles.
- Long reply AA,BB,CC,DD,EE,FF → `rsp_data_o`=`32'hCCDD_EEFF`. Stray bytes in IDLE → no effect.
- Simultaneous: `rx_last` in the timer==TIMEOUT_CYC-1 cycle → err=0.
- Reset during WAIT_RSP → all outputs 0 next cycle. A subsequent req1 is granted normally, pointer starting at 0.

Source files
------------

// File: rtl/laser_cmd_pkg.sv
// Shared types and constants for the laser command scheduler.
package laser_cmd_pkg;

    localparam int         LASER_CMD_W = 32;
    localparam logic [7:0] LASER_EOF   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/laser_cmd_sched_if.sv
// Requester-side and laser-link-side signals of the command scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface laser_cmd_sched_if #(
    parameter int REQ_NUM = 4
);
    import laser_cmd_pkg::*;

    logic [REQ_NUM-1:0]             req_i;
    logic [REQ_NUM*LASER_CMD_W-1:0] req_data_i;
    logic [REQ_NUM-1:0]             ack_o;
    logic [LASER_CMD_W-1:0]         rsp_data_o;
    logic                           rsp_err_o;
    logic                           busy_o;
    logic [LASER_CMD_W-1:0]         laser_tx_data_o;
    logic                           laser_tx_vld_o;
    logic [7:0]                     laser_rx_data_i;
    logic                           laser_rx_vld_i;
    logic                           laser_rx_last_i;

    modport slave (
        input  req_i, req_data_i, laser_rx_data_i, laser_rx_vld_i, laser_rx_last_i,
        output ack_o, rsp_data_o, rsp_err_o, busy_o, laser_tx_data_o, laser_tx_vld_o
    );

    modport master (
        output req_i, req_data_i, laser_rx_data_i, laser_rx_vld_i, laser_rx_last_i,
        input  ack_o, rsp_data_o, rsp_err_o, busy_o, laser_tx_data_o, laser_tx_vld_o
    );

endinterface

// File: rtl/laser_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// requester at or after the priority pointer, wrapping around.
module laser_rr_arbiter #(
    parameter  int REQ_NUM = 4,
    localparam int PW      = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [REQ_NUM-1:0] grant
);

    // Scan requesters starting at ptr, first active one wins.
    always_comb begin
        logic        found;
        logic [PW:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(REQ_NUM)) begin
                idx = idx - (PW+1)'(REQ_NUM);
            end
            if (!found && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/laser_cmd_sched.sv
// Laser command scheduler: shares one laser UART path between REQ_NUM
// requesters, sends a 32-bit command, collects reply bytes up to the 0xFF
// end-of-frame byte or a timeout, and acks the issuing requester.
// Optional feature macro: LASER_CMD_RETRY_EN (resend once on first timeout).
module laser_cmd_sched
    import laser_cmd_pkg::*;
#(
    parameter int REQ_NUM     = 4,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    laser_cmd_sched_if.slave  bus
);

    localparam int          PW         = $clog2(REQ_NUM);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYC - 1);

    state_t                  state_reg, state_next;
    logic [PW-1:0]           ptr_reg, ptr_next;
    logic [REQ_NUM-1:0]      grant_comb, grant_reg, ack_reg;
    logic [LASER_CMD_W-1:0]  cmd_comb, cmd_reg;
    logic [LASER_CMD_W-1:0]  shadow_reg, shadow_next, rsp_data_reg;
    logic [31:0]             timer_reg;
    logic                    rsp_err_reg, err_next, busy_reg, tx_vld_reg, retry_fire;
`ifdef LASER_CMD_RETRY_EN
    logic                    retry_used_reg;
`endif

    laser_rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
        .req   (bus.req_i),
        .ptr   (ptr_reg),
        .grant (grant_comb)
    );

    // Mux out the granted command word and compute the pointer after this grant.
    always_comb begin
        cmd_comb = '0;
        ptr_next = ptr_reg;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant_comb[i]) begin
                cmd_comb = cmd_comb | bus.req_data_i[LASER_CMD_W*i +: LASER_CMD_W];
                ptr_next = (i == REQ_NUM - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Reply shadow with the current byte shifted in (oldest byte falls out).
    always_comb begin
        shadow_next = shadow_reg;
        if (bus.laser_rx_vld_i) begin
            shadow_next = {shadow_reg[23:0], bus.laser_rx_data_i};
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; end-of-frame takes precedence over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        retry_fire = 1'b0;
        case (state_reg)
            IDLE:     if (|bus.req_i) state_next = SEND;
            SEND:     state_next = WAIT_RSP;
            WAIT_RSP: begin
                if (bus.laser_rx_last_i) begin
                    state_next = DONE;
                end else if (timer_reg == TIMER_LAST) begin
`ifdef LASER_CMD_RETRY_EN
                    if (!retry_used_reg) begin
                        state_next = SEND;
                        retry_fire = 1'b1;
                    end else begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end
`else
                    state_next = DONE;
                    err_next   = 1'b1;
`endif
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg        <= '0;
            grant_reg      <= '0;
            ack_reg        <= '0;
            cmd_reg        <= '0;
            shadow_reg     <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            timer_reg      <= '0;
            busy_reg       <= 1'b0;
            tx_vld_reg     <= 1'b0;
`ifdef LASER_CMD_RETRY_EN
            retry_used_reg <= 1'b0;
`endif
        end else begin
            tx_vld_reg <= (state_next == SEND);
            busy_reg   <= (state_next != IDLE);
            ack_reg    <= (state_next == DONE) ? grant_reg : '0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req_i) begin
                        grant_reg      <= grant_comb;
                        cmd_reg        <= cmd_comb;
                        ptr_reg        <= ptr_next;
                        shadow_reg     <= '0;
                        timer_reg      <= '0;
`ifdef LASER_CMD_RETRY_EN
                        retry_used_reg <= 1'b0;
`endif
                    end
                end
                WAIT_RSP: begin
                    if (retry_fire) begin
                        timer_reg      <= '0;
                        shadow_reg     <= '0;
`ifdef LASER_CMD_RETRY_EN
                        retry_used_reg <= 1'b1;
`endif
                    end else begin
                        if (timer_reg != '1) timer_reg <= timer_reg + 32'd1;
                        shadow_reg <= shadow_next;
                    end
                    if (state_next == DONE) begin
                        rsp_data_reg <= shadow_next;
                        rsp_err_reg  <= err_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack_o           = ack_reg;
    assign bus.rsp_data_o      = rsp_data_reg;
    assign bus.rsp_err_o       = rsp_err_reg;
    assign bus.busy_o          = busy_reg;
    assign bus.laser_tx_data_o = cmd_reg;
    assign bus.laser_tx_vld_o  = tx_vld_reg;

endmodule

// File: tb/tb_laser_cmd_sched.sv
// Directed testbench for laser_cmd_sched (4 requesters, 100-cycle timeout).
module tb_laser_cmd_sched;
    import laser_cmd_pkg::*;

    localparam int N = 4;
    localparam int T = 100;
`ifdef LASER_CMD_RETRY_EN
    localparam int TO_STEPS   = 2*T + 2;
    localparam int TO_STROBES = 2;
`else
    localparam int TO_STEPS   = T + 1;
    localparam int TO_STROBES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    laser_cmd_sched_if #(.REQ_NUM(N)) bus_if ();

    laser_cmd_sched #(.REQ_NUM(N), .TIMEOUT_CYC(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        bus_if.req_data_i[32*i +: 32] = w;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.laser_rx_data_i = b;
        bus_if.laser_rx_vld_i  = 1'b1;
        bus_if.laser_rx_last_i = (b == LASER_EOF);
        step;
        bus_if.laser_rx_vld_i  = 1'b0;
        bus_if.laser_rx_last_i = 1'b0;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        while (bus_if.laser_tx_vld_o !== 1'b1 && n < 50) begin
            step;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total_cnt++;
        if (bus_if.ack_o !== 4'b0) $display("FAIL reset_ack: got %b want 0000", bus_if.ack_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.busy_o !== 1'b0 || bus_if.laser_tx_vld_o !== 1'b0)
            $display("FAIL reset_busy_txvld: got %b%b want 00", bus_if.busy_o, bus_if.laser_tx_vld_o);
        else pass_cnt++;
        total_cnt++;
        if ({bus_if.rsp_data_o, bus_if.rsp_err_o, bus_if.laser_tx_data_o} !== 65'b0)
            $display("FAIL reset_data: got rsp %h err %b tx %h want all 0",
                     bus_if.rsp_data_o, bus_if.rsp_err_o, bus_if.laser_tx_data_o);
        else pass_cnt++;
        rst = 1'b0;
        step;
    endtask

    task automatic test_single;
        int n;
        set_word(0, 32'h1122_33FF);
        bus_if.req_i = 4'b0001;
        wait_tx(n);
        total_cnt++;
        if (n !== 1) $display("FAIL single_tx_latency: got %0d want 1", n);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.laser_tx_data_o !== 32'h1122_33FF || bus_if.busy_o !== 1'b1)
            $display("FAIL single_tx_word: got %h busy %b want 112233ff busy 1",
                     bus_if.laser_tx_data_o, bus_if.busy_o);
        else pass_cnt++;
        step;
        total_cnt++;
        if (bus_if.laser_tx_vld_o !== 1'b0) $display("FAIL single_tx_one_cycle: got %b want 0", bus_if.laser_tx_vld_o);
        else pass_cnt++;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b0001 || bus_if.rsp_data_o !== 32'h1122_33FF || bus_if.rsp_err_o !== 1'b0)
            $display("FAIL single_ack: got ack %b rsp %h err %b want 0001 112233ff 0",
                     bus_if.ack_o, bus_if.rsp_data_o, bus_if.rsp_err_o);
        else pass_cnt++;
        bus_if.req_i = 4'b0000;
        $display("txn single: req0 rsp %h err %b", bus_if.rsp_data_o, bus_if.rsp_err_o);
        step;
        total_cnt++;
        if (bus_if.ack_o !== 4'b0 || bus_if.busy_o !== 1'b0 || bus_if.rsp_data_o !== 32'h1122_33FF)
            $display("FAIL single_after_ack: got ack %b busy %b rsp %h want 0000 0 112233ff",
                     bus_if.ack_o, bus_if.busy_o, bus_if.rsp_data_o);
        else pass_cnt++;
    endtask

    task automatic test_contention;
        int n;
        int ord1[4] = '{0, 1, 2, 3};
        int ord2[2] = '{0, 2};
        logic [N-1:0] exp_oh;
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_word(i, 32'hC0DE_0000 | 32'(i));
        bus_if.req_i = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            int g;
            g = (j < 4) ? ord1[j] : ord2[j-4];
            if (j == 4) bus_if.req_i = 4'b0101;
            exp_oh = 4'b0001 << g;
            wait_tx(n);
            total_cnt++;
            if (n !== ((j == 0) ? 1 : 2))
                $display("FAIL contention_tx_latency[%0d]: got %0d want %0d", j, n, (j == 0) ? 1 : 2);
            else pass_cnt++;
            total_cnt++;
            if (bus_if.laser_tx_data_o !== (32'hC0DE_0000 | 32'(g)))
                $display("FAIL contention_word[%0d]: got %h want %h", j,
                         bus_if.laser_tx_data_o, 32'hC0DE_0000 | 32'(g));
            else pass_cnt++;
            step;
            send_byte(8'hFF);
            total_cnt++;
            if (bus_if.ack_o !== exp_oh)
                $display("FAIL contention_ack[%0d]: got %b want %b", j, bus_if.ack_o, exp_oh);
            else pass_cnt++;
            $display("txn contention: grant %0d ack %b", g, bus_if.ack_o);
            bus_if.req_i[g] = 1'b0;
        end
        step;
    endtask

    task automatic test_timeout;
        int n;
        int steps;
        int strobes;
        set_word(0, 32'hDEAD_0001);
        bus_if.req_i = 4'b0001;
        wait_tx(n);
        steps   = 0;
        strobes = (n < 50) ? 1 : 0;
        while (bus_if.ack_o === 4'b0 && steps < 600) begin
            step;
            steps++;
            if (bus_if.laser_tx_vld_o === 1'b1) strobes++;
        end
        total_cnt++;
        if (steps !== TO_STEPS) $display("FAIL timeout_cycles: got %0d want %0d", steps, TO_STEPS);
        else pass_cnt++;
        total_cnt++;
        if (strobes !== TO_STROBES) $display("FAIL timeout_strobes: got %0d want %0d", strobes, TO_STROBES);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.ack_o !== 4'b0001 || bus_if.rsp_err_o !== 1'b1 || bus_if.rsp_data_o !== 32'h0)
            $display("FAIL timeout_status: got ack %b err %b rsp %h want 0001 1 00000000",
                     bus_if.ack_o, bus_if.rsp_err_o, bus_if.rsp_data_o);
        else pass_cnt++;
        $display("txn timeout: req0 err %b after %0d cycles", bus_if.rsp_err_o, steps);
        bus_if.req_i = 4'b0000;
        step;
    endtask

    task automatic test_long_reply;
        int n;
        set_word(1, 32'h0000_0A01);
        bus_if.req_i = 4'b0010;
        wait_tx(n);
        step;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b0010 || bus_if.rsp_data_o !== 32'hCCDD_EEFF || bus_if.rsp_err_o !== 1'b0)
            $display("FAIL long_reply: got ack %b rsp %h err %b want 0010 ccddeeff 0",
                     bus_if.ack_o, bus_if.rsp_data_o, bus_if.rsp_err_o);
        else pass_cnt++;
        $display("txn long_reply: req1 rsp %h", bus_if.rsp_data_o);
        bus_if.req_i = 4'b0000;
        step;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hFF);
        step;
        total_cnt++;
        if (bus_if.ack_o !== 4'b0 || bus_if.busy_o !== 1'b0 || bus_if.rsp_data_o !== 32'hCCDD_EEFF)
            $display("FAIL stray_idle: got ack %b busy %b rsp %h want 0000 0 ccddeeff",
                     bus_if.ack_o, bus_if.busy_o, bus_if.rsp_data_o);
        else pass_cnt++;
        set_word(0, 32'h0000_0B00);
        bus_if.req_i = 4'b0001;
        wait_tx(n);
        step;
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b0001 || bus_if.rsp_data_o !== 32'h0000_00FF)
            $display("FAIL shadow_cleared: got ack %b rsp %h want 0001 000000ff",
                     bus_if.ack_o, bus_if.rsp_data_o);
        else pass_cnt++;
        $display("txn short_reply: req0 rsp %h", bus_if.rsp_data_o);
        bus_if.req_i = 4'b0000;
        step;
    endtask

    task automatic test_simultaneous;
        int n;
        set_word(0, 32'h5151_0000);
        bus_if.req_i = 4'b0001;
        wait_tx(n);
        repeat (T) step;
        total_cnt++;
        if (bus_if.ack_o !== 4'b0 || bus_if.busy_o !== 1'b1)
            $display("FAIL simul_pending: got ack %b busy %b want 0000 1", bus_if.ack_o, bus_if.busy_o);
        else pass_cnt++;
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b0001 || bus_if.rsp_err_o !== 1'b0 || bus_if.rsp_data_o !== 32'h0000_00FF)
            $display("FAIL simul_last_wins: got ack %b err %b rsp %h want 0001 0 000000ff",
                     bus_if.ack_o, bus_if.rsp_err_o, bus_if.rsp_data_o);
        else pass_cnt++;
        $display("txn simultaneous: req0 err %b", bus_if.rsp_err_o);
        bus_if.req_i = 4'b0000;
        step;
    endtask

    task automatic test_reset_mid;
        int n;
        set_word(2, 32'h2222_0002);
        bus_if.req_i = 4'b0100;
        wait_tx(n);
        step;
        repeat (5) step;
        send_byte(8'h55);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus_if.ack_o, bus_if.busy_o, bus_if.laser_tx_vld_o, bus_if.rsp_err_o} !== 7'b0 ||
            bus_if.rsp_data_o !== 32'h0 || bus_if.laser_tx_data_o !== 32'h0)
            $display("FAIL reset_mid_async: got busy %b tx %h rsp %h want all 0",
                     bus_if.busy_o, bus_if.laser_tx_data_o, bus_if.rsp_data_o);
        else pass_cnt++;
        bus_if.req_i = 4'b0000;
        step;
        total_cnt++;
        if (bus_if.busy_o !== 1'b0 || bus_if.laser_tx_vld_o !== 1'b0 || bus_if.ack_o !== 4'b0)
            $display("FAIL reset_mid_hold: got busy %b txvld %b ack %b want 0 0 0000",
                     bus_if.busy_o, bus_if.laser_tx_vld_o, bus_if.ack_o);
        else pass_cnt++;
        rst = 1'b0;
        set_word(1, 32'h1111_0001);
        set_word(3, 32'h3333_0003);
        bus_if.req_i = 4'b1010;
        wait_tx(n);
        total_cnt++;
        if (bus_if.laser_tx_data_o !== 32'h1111_0001)
            $display("FAIL reset_ptr_word: got %h want 11110001", bus_if.laser_tx_data_o);
        else pass_cnt++;
        step;
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b0010 || bus_if.rsp_data_o !== 32'h0000_00FF)
            $display("FAIL reset_ptr_ack1: got ack %b rsp %h want 0010 000000ff",
                     bus_if.ack_o, bus_if.rsp_data_o);
        else pass_cnt++;
        $display("txn after_reset: req1 ack %b", bus_if.ack_o);
        bus_if.req_i[1] = 1'b0;
        wait_tx(n);
        step;
        send_byte(8'hFF);
        total_cnt++;
        if (bus_if.ack_o !== 4'b1000)
            $display("FAIL reset_ptr_ack3: got %b want 1000", bus_if.ack_o);
        else pass_cnt++;
        $display("txn after_reset: req3 ack %b", bus_if.ack_o);
        bus_if.req_i = 4'b0000;
        step;
    endtask

    initial begin
        bus_if.req_i           = '0;
        bus_if.req_data_i      = '0;
        bus_if.laser_rx_data_i = '0;
        bus_if.laser_rx_vld_i  = 1'b0;
        bus_if.laser_rx_last_i = 1'b0;
        test_reset;
        test_single;
        test_contention;
        test_timeout;
        test_long_reply;
        test_simultaneous;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
